// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding,
// protocol byte values and header field positions within a frame.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_RESP  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Position of each header byte after the sync byte.
    localparam logic [1:0] HDR_ADDR_HI = 2'd0;
    localparam logic [1:0] HDR_ADDR_LO = 2'd1;
    localparam logic [1:0] HDR_LEN_HI  = 2'd2;
    localparam logic [1:0] HDR_LEN_LO  = 2'd3;

endpackage

// File: rtl/boot_rx_timer.sv
// Inter-byte idle timer for the boot loader.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - received byte this cycle; restarts the count
//   enable     - states in which silence is timed
//   expired_c  - pulses on the TIMEOUT_CYCLES-th consecutive idle enabled cycle
module boot_rx_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // A byte in the final idle cycle wins over the timeout.
    assign expired_c = enable && !clear && (count_q == LAST_IDLE);

    // Count holds the number of idle cycles already elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || !enable || expired_c) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives a framed image from the SPART, writes it to
// memory as 16-bit words, checks the checksum, answers ACK/NAK and releases
// the CPU at the image start address after a good load.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rx_valid, rx_data         - received byte strobe and value
//   tx_full, tx_send, tx_data - transmit back-pressure, strobe and byte
//   mem_we, mem_addr,
//   mem_wdata, mem_ack        - word write port, request held until ack
//   cpu_hold, boot_pc,
//   boot_done                 - CPU reset hold, start address, release pulse
module uart_boot_loader #(
    parameter logic [15:0] RESERVED       = 16'h0100,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_full,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic [15:0] boot_pc,
    output logic        boot_done
);

    import boot_pkg::*;

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned WORD_W = 16;

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] ptr_q, ptr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        resp_q, resp_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              tx_send_q, tx_send_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [WORD_W-1:0] boot_pc_q, boot_pc_d;
    logic              boot_done_q, boot_done_d;

    logic              timer_en_c;
    logic              timeout_c;
    logic              ack_c;
    logic [WORD_W-1:0] ptr_adv_c;
    logic [WORD_W-1:0] len_new_c;
    logic [CNT_W-1:0]  end_addr_c;
    logic              hdr_bad_c;

    assign timer_en_c = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                        (state_q == ST_CSUM) || (state_q == ST_DRAIN);

    boot_rx_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (rx_valid),
        .enable    (timer_en_c),
        .expired_c (timeout_c)
    );

    // Pointer value after any acknowledge this cycle, so a word completing
    // together with an ack lands at the following address.
    assign ack_c     = mem_we_q && mem_ack;
    assign ptr_adv_c = ack_c ? ptr_q + WORD_W'(1) : ptr_q;

    // Header check on the final header byte; end address in 17 bits.
    assign len_new_c  = {len_q[15:8], rx_data};
    assign end_addr_c = CNT_W'(addr_q) + CNT_W'(len_new_c) - CNT_W'(1);
    assign hdr_bad_c  = (addr_q < RESERVED) || (len_new_c == '0) ||
                        (end_addr_c > CNT_W'(17'h0FFFF));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            csum_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            ptr_q       <= '0;
            hi_q        <= '0;
            resp_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            boot_pc_q   <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            hi_q        <= hi_d;
            resp_q      <= resp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            cpu_hold_q  <= cpu_hold_d;
            boot_pc_q   <= boot_pc_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        hi_d        = hi_q;
        resp_d      = resp_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_send_d   = 1'b0;
        tx_data_d   = tx_data_q;
        cpu_hold_d  = cpu_hold_q;
        boot_pc_d   = boot_pc_q;
        boot_done_d = 1'b0;

        // A pending write retires in whatever state the FSM is in.
        if (ack_c) begin
            mem_we_d = 1'b0;
            ptr_d    = ptr_q + WORD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_HDR;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end

            ST_HDR: begin
                if (rx_valid) begin
                    csum_d = csum_q + rx_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    case (cnt_q[1:0])
                        HDR_ADDR_HI: addr_d = {rx_data, addr_q[7:0]};
                        HDR_ADDR_LO: addr_d = {addr_q[15:8], rx_data};
                        HDR_LEN_HI:  len_d  = {rx_data, len_q[7:0]};
                        HDR_LEN_LO: begin
                            len_d   = len_new_c;
                            cnt_d   = '0;
                            ptr_d   = addr_q;
                            state_d = hdr_bad_c ? ST_DRAIN : ST_DATA;
                        end
                        default: ;
                    endcase
                end else if (timeout_c) begin
                    resp_d  = NAK_BYTE;
                    state_d = ST_RESP;
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q + rx_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (!cnt_q[0]) begin
                        hi_d = rx_data;
                    end else if (mem_we_q && !mem_ack) begin
                        state_d = ST_DRAIN;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_adv_c;
                        mem_wdata_d = {hi_q, rx_data};
                    end
                    if ((state_d == ST_DATA) && (cnt_d == {len_q, 1'b0})) begin
                        state_d = ST_CSUM;
                    end
                end else if (timeout_c) begin
                    resp_d  = NAK_BYTE;
                    state_d = ST_RESP;
                end
            end

            ST_CSUM: begin
                if (rx_valid) begin
                    resp_d  = (rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
                    state_d = ST_RESP;
                end else if (timeout_c) begin
                    resp_d  = NAK_BYTE;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (!mem_we_q && !tx_full) begin
                    tx_send_d = 1'b1;
                    tx_data_d = resp_q;
                    state_d   = (resp_q == ACK_BYTE) ? ST_DONE : ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (timeout_c) begin
                    resp_d  = NAK_BYTE;
                    state_d = ST_RESP;
                end
            end

            ST_DONE: begin
                cpu_hold_d  = 1'b0;
                boot_pc_d   = addr_q;
                boot_done_d = cpu_hold_q;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_send   = tx_send_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign boot_pc   = boot_pc_q;
    assign boot_done = boot_done_q;

endmodule
